// File: rtl/decrypt_1block_128a.sv
// Ascon-128a single-block authenticated decryption: one full AD block, one full
// ciphertext block, one permutation round per clock over a 320-bit state.
module decrypt_1block_128a #(
  parameter logic [63:0] IV       = 64'h80800c0800000000,
  parameter int          ROUNDS_A = 12,
  parameter int          ROUNDS_B = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [127:0] A,
  input  logic [127:0] C,
  input  logic [127:0] T,
  output logic [127:0] P,
  output logic         busy,
  output logic         done,
  output logic         tag_ok,
  output logic [2:0]   dbg_state
);

  // Handshake: start is taken on a rising edge while idle (busy=0); done then
  // pulses for one cycle exactly 49 edges later with P/tag_ok valid, and those
  // hold until the next accepted start clears them.
  typedef enum logic [2:0] {IDLE, INIT, AD, ADPAD, CT, FINAL} state_t;

  localparam logic [3:0] RA0  = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RB0  = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST = 4'd11;
  localparam logic [3:0] CMP  = 4'd12;

  state_t       st;
  logic [3:0]   cnt;
  logic [319:0] s;
  logic [319:0] rnd;
  logic [127:0] k_r, a_r, c_r, t_r, ptmp;
  logic         tag_match;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int sh);
    return (v >> sh) | (v << (64 - sh));
  endfunction

  // One Ascon round on the current state; constant index follows cnt so the
  // b-round permutation is the tail of the a-round schedule.
  always_comb begin
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, ~cnt, cnt};
    x3 = s[127:64];
    x4 = s[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    rnd = {x0 ^ rotr(x0, 19) ^ rotr(x0, 28),
           x1 ^ rotr(x1, 61) ^ rotr(x1, 39),
           x2 ^ rotr(x2, 1)  ^ rotr(x2, 6),
           x3 ^ rotr(x3, 10) ^ rotr(x3, 17),
           x4 ^ rotr(x4, 7)  ^ rotr(x4, 41)};
  end

  assign tag_match = ((s[127:0] ^ k_r) == t_r);
  assign dbg_state = st;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st     <= IDLE;
      cnt    <= 4'd0;
      s      <= '0;
      k_r    <= '0;
      a_r    <= '0;
      c_r    <= '0;
      t_r    <= '0;
      ptmp   <= '0;
      P      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tag_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            k_r    <= SK;
            a_r    <= A;
            c_r    <= C;
            t_r    <= T;
            s      <= {IV, SK, N};
            cnt    <= RA0;
            busy   <= 1'b1;
            P      <= '0;
            tag_ok <= 1'b0;
            st     <= INIT;
          end
        end
        INIT: begin
          cnt <= cnt + 4'd1;
          s   <= rnd;
          if (cnt == LAST) begin
            s   <= {rnd[319:192] ^ a_r, rnd[191:128], rnd[127:0] ^ k_r};
            cnt <= RB0;
            st  <= AD;
          end
        end
        AD: begin
          cnt <= cnt + 4'd1;
          s   <= rnd;
          if (cnt == LAST) begin
            s   <= rnd ^ {1'b1, 319'd0};
            cnt <= RB0;
            st  <= ADPAD;
          end
        end
        ADPAD: begin
          cnt <= cnt + 4'd1;
          s   <= rnd;
          if (cnt == LAST) begin
            // Domain bit lands in bit 0, so the rate half is untouched by it.
            ptmp <= rnd[319:192] ^ c_r;
            s    <= {c_r, rnd[191:1], ~rnd[0]};
            cnt  <= RB0;
            st   <= CT;
          end
        end
        CT: begin
          cnt <= cnt + 4'd1;
          s   <= rnd;
          if (cnt == LAST) begin
            s   <= rnd ^ {1'b1, 127'd0, k_r, 64'd0};
            cnt <= RA0;
            st  <= FINAL;
          end
        end
        FINAL: begin
          if (cnt == CMP) begin
            tag_ok <= tag_match;
            P      <= tag_match ? ptmp : 128'd0;
            done   <= 1'b1;
            busy   <= 1'b0;
            cnt    <= 4'd0;
            st     <= IDLE;
          end else begin
            s   <= rnd;
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          st   <= IDLE;
          cnt  <= 4'd0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_1block_128a.sv
// Bench for decrypt_1block_128a: an independent Ascon-128a encryption model
// produces ciphertext/tag; a scoreboard checks plaintext, tag_ok and done timing.
module tb_decrypt_1block_128a;

  localparam logic [63:0] IV_TB = 64'h80800c0800000000;
  localparam int LAT = 49;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [127:0] SK = '0, N = '0, A = '0, C = '0, T = '0;
  logic [127:0] P;
  logic         busy, done, tag_ok;
  logic [2:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [128:0] exp_q[$];
  int           exp_cyc_q[$];

  logic [4:0] sbox_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  decrypt_1block_128a dut (
    .CLK(CLK), .RST(RST), .start(start), .SK(SK), .N(N), .A(A), .C(C), .T(T),
    .P(P), .busy(busy), .done(done), .tag_ok(tag_ok), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // reference model: table-driven S-box, column by column
  function automatic logic [63:0] ror(input logic [63:0] v, input int sh);
    return (v >> sh) | (v << (64 - sh));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [4:0]  col;
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        col = sbox_t[col];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = col;
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic void enc(input logic [127:0] k, n, a, p,
                              output logic [127:0] c, t);
    logic [319:0] s;
    s = perm({IV_TB, k, n}, 12);
    s[127:0]   = s[127:0] ^ k;
    s[319:192] = s[319:192] ^ a;
    s = perm(s, 8);
    s[319] = ~s[319];
    s = perm(s, 8);
    s[0] = ~s[0];
    c = s[319:192] ^ p;
    s[319:192] = c;
    s = perm(s, 8);
    s[319] = ~s[319];
    s[191:64] = s[191:64] ^ k;
    s = perm(s, 12);
    t = s[127:0] ^ k;
  endfunction

  // scoreboard helpers
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing expected", cyc);
      end else begin
        logic [128:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("done_cycle", 128'(cyc), 128'(ec));
        check("P", P, e[127:0]);
        check("tag_ok", {127'd0, tag_ok}, {127'd0, e[128]});
      end
    end
  end

  // driver tasks
  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (done === 1'b1) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", bound, cyc);
  endtask

  task automatic issue(input logic [127:0] k, n, a, c, t,
                       input logic exp_ok, input logic [127:0] exp_p);
    SK = k; N = n; A = a; C = c; T = t;
    start = 1'b1;
    exp_q.push_back({exp_ok, exp_p});
    exp_cyc_q.push_back(cyc + 1 + LAT);
  endtask

  task automatic run_op(input logic [127:0] k, n, a, c, t,
                        input logic exp_ok, input logic [127:0] exp_p, input logic rel);
    @(negedge CLK);
    if (rel) RST = 1'b1;
    issue(k, n, a, c, t, exp_ok, exp_p);
    @(negedge CLK);
    start = 1'b0;
    check("busy_after_start", {127'd0, busy}, 128'd1);
    check("P_cleared", P, 128'd0);
    check("tag_ok_cleared", {127'd0, tag_ok}, 128'd0);
    wait_done(LAT + 10);
  endtask

  logic [127:0] k2, n2, a2, p2, c0, t0, c2, t2, kr, nr, ar, pr, cr, tr, cf;
  int base;

  initial begin
    #3 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_P", P, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_tag_ok", {127'd0, tag_ok}, 128'd0);
    check("rst_state", {125'd0, dbg_state}, 128'd0);

    // all-zero vector; start accepted on the edge that releases reset
    enc('0, '0, '0, '0, c0, t0);
    run_op('0, '0, '0, c0, t0, 1'b1, '0, 1'b1);
    run_op('0, '0, '0, c0, t0 ^ 128'd1, 1'b0, '0, 1'b0);

    k2 = 128'h000102030405060708090a0b0c0d0e0f;
    n2 = 128'h101112131415161718191a1b1c1d1e1f;
    a2 = 128'h202122232425262728292a2b2c2d2e2f;
    p2 = 128'h00112233445566778899aabbccddeeff;
    enc(k2, n2, a2, p2, c2, t2);
    run_op(k2, n2, a2, c2, t2, 1'b1, p2, 1'b0);
    repeat (5) begin
      @(negedge CLK);
      check("P_hold", P, p2);
      check("tag_ok_hold", {127'd0, tag_ok}, 128'd1);
    end
    run_op(k2, n2, a2, c2 ^ {1'b1, 127'd0}, t2, 1'b0, '0, 1'b0);
    run_op(k2 ^ 128'd4, n2, a2, c2, t2, 1'b0, '0, 1'b0);

    // start pulses and input churn while busy must not disturb the operation
    @(negedge CLK);
    issue(k2, n2, a2, c2, t2, 1'b1, p2);
    base = cyc + 1;
    for (int i = 0; i < 48; i++) begin
      @(negedge CLK);
      start = ((cyc - base) == 10) || ((cyc - base) == 30);
      SK = {$urandom, $urandom, $urandom, $urandom};
      C  = {$urandom, $urandom, $urandom, $urandom};
      T  = {$urandom, $urandom, $urandom, $urandom};
    end
    start = 1'b0;
    wait_done(10);

    // asynchronous reset in the middle of an operation
    @(negedge CLK);
    issue(k2, n2, a2, c2, t2, 1'b1, p2);
    base = cyc + 1;
    @(negedge CLK);
    start = 1'b0;
    while ((cyc - base) < 25) @(negedge CLK);
    #2 RST = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_done", {127'd0, done}, 128'd0);
    check("abort_P", P, 128'd0);
    repeat (3) @(negedge CLK);
    check("abort_state", {125'd0, dbg_state}, 128'd0);
    run_op(k2, n2, a2, c2, t2, 1'b1, p2, 1'b1);

    // start held high: back-to-back operations every 50 cycles
    @(negedge CLK);
    issue(k2, n2, a2, c2, t2, 1'b1, p2);
    base = cyc + 1;
    for (int j = 1; j < 4; j++) begin
      exp_q.push_back({1'b1, p2});
      exp_cyc_q.push_back(base + LAT + 50 * j);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      check("busy_hold", {127'd0, busy}, (((cyc - base) % 50) == 49) ? 128'd0 : 128'd1);
    end
    start = 1'b0;

    // random round trips, with an occasional flipped ciphertext bit
    for (int i = 0; i < 500; i++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      nr = {$urandom, $urandom, $urandom, $urandom};
      ar = {$urandom, $urandom, $urandom, $urandom};
      pr = {$urandom, $urandom, $urandom, $urandom};
      enc(kr, nr, ar, pr, cr, tr);
      run_op(kr, nr, ar, cr, tr, 1'b1, pr, 1'b0);
      if ((i % 8) == 0) begin
        cf = cr;
        cf[$urandom_range(0, 127)] ^= 1'b1;
        run_op(kr, nr, ar, cf, tr, 1'b0, '0, 1'b0);
      end
    end

    repeat (60) @(negedge CLK);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
